// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
//   Bit-serial subtractor controller. A single 1-bit full-subtractor cell is
//   stepped LSB first, one bit per clock, to form diff = a - b - bin
//   (modulo 2^WIDTH) and the final borrow out.
//
//   Optional feature: define SERIAL_SUB_ZFLAG_EN to add output 'zero'
//   (1 when the result is zero; updated with the result, held with diff).
//
// Parameters
//   WIDTH  operand width in bits (2..32), default 8
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a subtraction (sampled only in IDLE)
//   a, b   in   minuend / subtrahend, captured on an accepted start
//   bin    in   borrow-in, captured on an accepted start
//   busy   out  high while RUN or DONE
//   done   out  one-cycle pulse when diff/bout are valid
//   diff   out  result, held until the next accepted start
//   bout   out  final borrow out, held until the next accepted start
//   zero   out  (SERIAL_SUB_ZFLAG_EN only) diff == 0 flag
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_ZFLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             bout_r;

  // Full-subtractor cell operating on the current LSBs and the borrow reg.
  logic             cell_x;
  logic             cell_y;
  logic             cell_z;
  logic             cell_d;
  logic             cell_b;
  logic [WIDTH-1:0] diff_next;

  always_comb begin
    cell_x    = a_sr[0];
    cell_y    = b_sr[0];
    cell_z    = borrow;
    cell_d    = cell_x ^ cell_y ^ cell_z;
    cell_b    = (~cell_x & cell_y) | (~cell_x & cell_z) | (cell_y & cell_z);
    // Result bits enter from the MSB side so that after WIDTH shifts the
    // first (LSB) bit computed has reached bit 0.
    diff_next = {cell_d, diff_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
      bout_r  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SERIAL_SUB_ZFLAG_EN
      zero    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          diff_sr <= diff_next;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          borrow  <= cell_b;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Final bit: publish borrow/flag together with the last diff bit
            // so everything is valid in the DONE cycle.
            state  <= DONE;
            done   <= 1'b1;
            bout_r <= cell_b;
`ifdef SERIAL_SUB_ZFLAG_EN
            zero   <= (diff_next == '0);
`endif
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign diff = diff_sr;
  assign bout = bout_r;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl
//   Self-checking bench for serial_sub_ctrl (WIDTH=8). Expected results come
//   from plain modular arithmetic on the operands.
module tb_serial_sub_ctrl;

  localparam int unsigned W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         bin   = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_ZFLAG_EN
  logic         zero;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_ZFLAG_EN
    ,
    .zero  (zero)
`endif
  );

  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic z);
    int v;
    v = int'(x) - int'(y) - int'(z);
    return W'(v & ((1 << W) - 1));
  endfunction

  function automatic logic ref_bout(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic z);
    return int'(x) < (int'(y) + int'(z));
  endfunction

  // One complete operation: start pulse, bounded wait for done, latency,
  // result, done-pulse width and hold-after-done checks.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                        input string name, input bit rel_rst);
    logic [W-1:0] ed;
    logic         eb;
    int           c;
    bit           seen;
    ed = ref_diff(xa, xb, xbin);
    eb = ref_bout(xa, xb, xbin);
    @(negedge clk);
    a = xa; b = xb; bin = xbin; start = 1'b1;
    if (rel_rst) rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Operand changes after capture must not matter.
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    end
    c = 0; seen = 0;
    while (!seen && c < int'(W) + 4) begin
      if (done === 1'b1) seen = 1;
      else begin @(negedge clk); c++; end
    end
    total++;
    if (!seen || c != int'(W)) begin
      bad++; $display("FAIL %s latency: got %0d (seen=%0d) want %0d", name, c, seen, W);
    end
    total++;
    if (diff !== ed) begin
      bad++; $display("FAIL %s diff: got %h want %h", name, diff, ed);
    end
    total++;
    if (bout !== eb) begin
      bad++; $display("FAIL %s bout: got %b want %b", name, bout, eb);
    end
`ifdef SERIAL_SUB_ZFLAG_EN
    total++;
    if (zero !== (ed == '0)) begin
      bad++; $display("FAIL %s zero: got %b want %b", name, zero, (ed == '0));
    end
`endif
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s end_of_op: got done=%b busy=%b want 0 0", name, done, busy);
    end
    total++;
    if (diff !== ed || bout !== eb) begin
      bad++; $display("FAIL %s hold: got %h/%b want %h/%b", name, diff, bout, ed, eb);
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
      bad++; $display("FAIL reset_state: got busy=%b done=%b diff=%h bout=%b want 0 0 00 0",
                      busy, done, diff, bout);
    end
`ifdef SERIAL_SUB_ZFLAG_EN
    total++;
    if (zero !== 1'b0) begin
      bad++; $display("FAIL reset_zero: got %b want 0", zero);
    end
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(8'h05, 8'h03, 1'b0, "sub_5_3", 0);
    run_op(8'h03, 8'h05, 1'b0, "sub_3_5", 0);
    run_op(8'h00, 8'h00, 1'b1, "sub_0_0_bin", 0);
    run_op(8'hA7, 8'hA7, 1'b0, "equal", 0);
    run_op(8'hFF, 8'h00, 1'b0, "max_min", 0);
    run_op(8'h00, 8'hFF, 1'b1, "min_max_bin", 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rand%0d", i), 0);
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] ed;
    logic         eb;
    int           ndone;
    int           first;
    bit           late_busy;
    ed = ref_diff(8'h3C, 8'h11, 1'b1);
    eb = ref_bout(8'h3C, 8'h11, 1'b1);
    @(negedge clk);
    a = 8'h3C; b = 8'h11; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; first = -1; late_busy = 0;
    for (int c = 0; c < int'(W) + 8; c++) begin
      if (c == 3) begin start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b0; end
      if (c == 4) start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) begin
          first = c;
          total++;
          if (diff !== ed || bout !== eb) begin
            bad++; $display("FAIL ignore_start result: got %h/%b want %h/%b", diff, bout, ed, eb);
          end
        end
      end
      if (c > int'(W) && busy !== 1'b0) late_busy = 1;
      @(negedge clk);
    end
    total++;
    if (ndone != 1 || first != int'(W)) begin
      bad++; $display("FAIL ignore_start done: got count=%0d at=%0d want 1 at %0d", ndone, first, W);
    end
    total++;
    if (late_busy) begin
      bad++; $display("FAIL ignore_start queued: got busy after done want idle");
    end
  endtask

  task automatic test_reset_mid_run();
    bit stray_done;
    @(negedge clk);
    a = 8'h77; b = 8'h22; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
      bad++; $display("FAIL reset_mid_run: got busy=%b done=%b diff=%h bout=%b want 0 0 00 0",
                      busy, done, diff, bout);
    end
    stray_done = 0;
    for (int i = 0; i < int'(W) + 2; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray_done = 1;
    end
    total++;
    if (stray_done) begin
      bad++; $display("FAIL reset_hold: got activity during reset want none");
    end
    // Release reset together with start: the first edge after release accepts it.
    run_op(8'h80, 8'h01, 1'b0, "post_reset", 1);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xa;
    logic [W-1:0] xb;
    logic         xbin;
    logic [W-1:0] ed;
    logic         eb;
    int           dt[$];
    logic         bz[30];
    xa = W'($urandom); xb = W'($urandom); xbin = 1'($urandom);
    ed = ref_diff(xa, xb, xbin);
    eb = ref_bout(xa, xb, xbin);
    @(negedge clk);
    a = xa; b = xb; bin = xbin; start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bz[i] = busy;
      if (done === 1'b1) begin
        dt.push_back(i);
        total++;
        if (diff !== ed || bout !== eb) begin
          bad++; $display("FAIL b2b result at %0d: got %h/%b want %h/%b", i, diff, bout, ed, eb);
        end
      end
    end
    start = 1'b0;
    total++;
    if (dt.size() != 3) begin
      bad++; $display("FAIL b2b done_count: got %0d want 3", dt.size());
    end
    for (int k = 1; k < dt.size(); k++) begin
      total++;
      if (dt[k] - dt[k-1] != int'(W) + 2) begin
        bad++; $display("FAIL b2b spacing: got %0d want %0d", dt[k] - dt[k-1], W + 2);
      end
    end
    for (int k = 0; k < dt.size(); k++) begin
      if (dt[k] + 2 < 30) begin
        total++;
        if (bz[dt[k] + 1] !== 1'b0 || bz[dt[k] + 2] !== 1'b1) begin
          bad++; $display("FAIL b2b busy_gap after %0d: got %b%b want 01",
                          dt[k], bz[dt[k] + 1], bz[dt[k] + 2]);
        end
      end
    end
    repeat (int'(W) + 4) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL b2b drain: got busy=%b want 0", busy);
    end
  endtask

`ifdef SERIAL_SUB_ZFLAG_EN
  task automatic test_zflag();
    run_op(8'h5A, 8'h5A, 1'b0, "zflag_eq", 0);
    total++;
    if (zero !== 1'b1) begin
      bad++; $display("FAIL zflag_set: got %b want 1", zero);
    end
    run_op(8'h5A, 8'h59, 1'b0, "zflag_ne", 0);
    total++;
    if (zero !== 1'b0 || diff !== 8'h01) begin
      bad++; $display("FAIL zflag_clr: got zero=%b diff=%h want 0 01", zero, diff);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SERIAL_SUB_ZFLAG_EN
    test_zflag();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each: minuend and subtrahend, captured on an accepted start.
REQ-006 The block SHALL have port bin, input, 1 bit: borrow-in, captured on an accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-009 The block SHALL have port diff, output, WIDTH bits: the result a - b - bin, modulo 2^WIDTH.
REQ-010 The block SHALL have port bout, output, 1 bit: final borrow out, high when a < b + bin (unsigned).

Function
REQ-011 The controller SHALL sequence one 1-bit full-subtractor cell, LSB first, one bit per clock; no WIDTH-bit parallel subtract is permitted.
REQ-012 The cell SHALL compute D = x^y^z and B = (~x&y)|(~x&z)|(y&z), where x = a bit, y = b bit, z = borrow register.
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE->RUN SHALL occur on a clock edge with start=1; that edge loads the a/b shift registers, sets borrow reg = bin and sets bit counter = 0.
REQ-015 Each RUN edge SHALL shift D into the diff shift register from the MSB side, shift a/b right by 1, load borrow reg with B, and increment the counter.
REQ-016 RUN->DONE SHALL occur on the edge where the counter reaches WIDTH-1, i.e. exactly WIDTH RUN edges.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, bout SHALL equal the borrow register, and the next edge SHALL return the FSM to IDLE.
REQ-018 Latency: with start sampled at edge N, done SHALL be high in the cycle after edge N+WIDTH.
REQ-019 diff and bout SHALL hold their values from DONE until the next accepted start, including after done drops.
REQ-020 start in RUN or DONE SHALL be ignored, with no queueing; a, b and bin changes after capture SHALL have no effect.
REQ-021 A start held continuously high SHALL begin a new operation on the edge after the FSM returns to IDLE; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-022 Boundary handling: a=b with bin=0 SHALL give diff=0, bout=0; a=0, b=0, bin=1 SHALL give diff all-ones, bout=1.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, diff=0, bout=0, counter=0 and clear all shift and borrow registers, independent of clk.
REQ-024 Reset asserted mid-RUN SHALL abandon the operation with no done pulse; after release, the first start SHALL behave as from power-up.
REQ-025 Reset release SHALL be sampled cleanly; start present on the first edge after release SHALL be accepted.

Configuration
REQ-026 Macro SERIAL_SUB_ZFLAG_EN defined: the block SHALL add output port zero, 1 bit, equal to 1 when diff==0, updated in DONE, held like diff, and reset to 0.
REQ-027 Macro SERIAL_SUB_ZFLAG_EN undefined: port zero and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 The bench SHALL cover: WIDTH=8, a=0x05, b=0x03, bin=0, start at edge 0 -> done high after edge 8, diff=0x02, bout=0.
REQ-029 The bench SHALL cover: a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-030 The bench SHALL cover: start pulsed again at RUN cycle 3 with a=0xFF -> ignored, first result unchanged, exactly one done pulse.
REQ-031 The bench SHALL cover: rst_n low at RUN cycle 4 -> busy=0, diff=0 and bout=0 at once, no done; the next op a=0x80, b=0x01 -> diff=0x7F, bout=0.
REQ-032 The bench SHALL cover: start held high for 30 cycles -> done pulses exactly 10 cycles apart and busy is low for exactly 1 cycle between operations.
REQ-033 The bench SHALL cover, with SERIAL_SUB_ZFLAG_EN defined: a=0x5A, b=0x5A, bin=0 -> zero=1; a=0x5A, b=0x59 -> zero=0, diff=0x01.
